// File: rtl/isp_wr_frame_gate.sv
// Frame gate from the ISP pixel stream to the DDR3 write FIFO: skips start-up frames and forces exact HxV geometry.
// Optional macro ISP_WR_GATE_PAD_EN builds the PAD state that fills short lines with 32'h000000FF.
module isp_wr_frame_gate #(
  parameter int DATA_WIDTH  = 8,
  parameter int H_PIXELS    = 1920,
  parameter int V_PIXELS    = 1080,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  in_vs,
  input  logic                  in_de,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_g,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_load,
  output logic                  out_wren,
  output logic [31:0]           out_data,
  output logic [15:0]           frame_cnt,
  output logic                  err_line,
  output logic                  err_frame
);
  localparam logic [11:0] H_LIM    = 12'(H_PIXELS);
  localparam logic [10:0] V_LIM    = 11'(V_PIXELS);
  localparam logic [3:0]  SKIP_LIM = 4'(SKIP_FRAMES);
  localparam logic [31:0] PAD_WORD = 32'h0000_00FF;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    LINE_WAIT,
    LINE,
`ifdef ISP_WR_GATE_PAD_EN
    PAD,
`endif
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] x_cnt, x_nxt;
  logic [10:0] y_cnt, y_nxt, y_inc;
  logic [3:0]  skip_cnt, skip_nxt;
  logic        vs_d, vs_rise, line_open, close_line;
  logic        load_nxt, wren_nxt, fcnt_inc, eline_set, eframe_set;
  logic [31:0] data_nxt, pix_word;

  assign vs_rise  = in_vs & ~vs_d;
  assign pix_word = {in_r, in_g, in_b, 8'hFF};
  assign y_inc    = y_cnt + 11'd1;
`ifdef ISP_WR_GATE_PAD_EN
  assign line_open = (state == LINE) || (state == PAD);
`else
  assign line_open = (state == LINE);
`endif

  always_comb begin
    state_nxt  = state;
    x_nxt      = x_cnt;
    y_nxt      = y_cnt;
    skip_nxt   = skip_cnt;
    load_nxt   = 1'b0;
    wren_nxt   = 1'b0;
    data_nxt   = pix_word;
    fcnt_inc   = 1'b0;
    eline_set  = 1'b0;
    eframe_set = 1'b0;
    close_line = 1'b0;
    if (vs_rise) begin
      // Frame boundary wins over any pixel or pad write in the same cycle.
      x_nxt = '0;
      y_nxt = '0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (SKIP_LIM == 4'd0) begin
              state_nxt = LINE_WAIT;
              load_nxt  = 1'b1;
            end else begin
              state_nxt = SKIP;
              skip_nxt  = '0;
            end
          end
        end
        SKIP: begin
          if (!enable) begin
            state_nxt = IDLE;
          end else if (skip_cnt + 4'd1 == SKIP_LIM) begin
            state_nxt = LINE_WAIT;
            load_nxt  = 1'b1;
          end else begin
            skip_nxt = skip_cnt + 4'd1;
          end
        end
        default: begin
          eframe_set = (line_open ? y_inc : y_cnt) < V_LIM;
          fcnt_inc   = (state == DONE);
          if (enable) begin
            state_nxt = LINE_WAIT;
            load_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      endcase
    end else begin
      case (state)
        LINE_WAIT: begin
          if (in_de) begin
            wren_nxt  = 1'b1;
            x_nxt     = 12'd1;
            state_nxt = LINE;
          end
        end
        LINE: begin
          if (in_de) begin
            if (x_cnt < H_LIM) begin
              wren_nxt = 1'b1;
              x_nxt    = x_cnt + 12'd1;
            end else begin
              eline_set = 1'b1;
            end
          end else if (x_cnt < H_LIM) begin
            eline_set = 1'b1;
`ifdef ISP_WR_GATE_PAD_EN
            // First fill word goes out on the fall cycle so pads follow the data without a bubble.
            wren_nxt = 1'b1;
            data_nxt = PAD_WORD;
            x_nxt    = x_cnt + 12'd1;
            if (x_cnt + 12'd1 == H_LIM) close_line = 1'b1;
            else                        state_nxt  = PAD;
`else
            close_line = 1'b1;
`endif
          end else begin
            close_line = 1'b1;
          end
        end
`ifdef ISP_WR_GATE_PAD_EN
        PAD: begin
          if (in_de) begin
            y_nxt = y_inc;
            if (y_inc == V_LIM) begin
              x_nxt     = '0;
              state_nxt = DONE;
            end else begin
              wren_nxt  = 1'b1;
              x_nxt     = 12'd1;
              state_nxt = LINE;
            end
          end else begin
            wren_nxt   = 1'b1;
            data_nxt   = PAD_WORD;
            x_nxt      = x_cnt + 12'd1;
            close_line = (x_cnt + 12'd1 == H_LIM);
          end
        end
`endif
        default: ;
      endcase
      if (close_line) begin
        x_nxt     = '0;
        y_nxt     = y_inc;
        state_nxt = (y_inc == V_LIM) ? DONE : LINE_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      vs_d      <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      skip_cnt  <= '0;
      out_load  <= 1'b0;
      out_wren  <= 1'b0;
      out_data  <= '0;
      frame_cnt <= '0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      state     <= state_nxt;
      vs_d      <= in_vs;
      x_cnt     <= x_nxt;
      y_cnt     <= y_nxt;
      skip_cnt  <= skip_nxt;
      out_load  <= load_nxt;
      out_wren  <= wren_nxt;
      if (wren_nxt) out_data <= data_nxt;
      frame_cnt <= frame_cnt + {15'd0, fcnt_inc};
      err_line  <= err_line | eline_set;
      err_frame <= err_frame | eframe_set;
    end
  end
endmodule

// File: tb/tb_isp_wr_frame_gate.sv
// Self-checking bench for isp_wr_frame_gate (H=8, V=4, SKIP=1): scenario table, corner sequences, random frames.
module tb_isp_wr_frame_gate;
  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rstn, enable, in_vs, in_de;
  logic [7:0]  in_r, in_g, in_b;
  logic        out_load, out_wren, err_line, err_frame;
  logic [31:0] out_data;
  logic [15:0] frame_cnt;

  isp_wr_frame_gate #(
    .DATA_WIDTH(8), .H_PIXELS(H), .V_PIXELS(V), .SKIP_FRAMES(1)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .in_vs(in_vs), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_load(out_load), .out_wren(out_wren), .out_data(out_data),
    .frame_cnt(frame_cnt), .err_line(err_line), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor: posedge count, write log and load count, sampled on the falling edge.
  int          pcyc = 0;
  int          loads = 0;
  bit          overlap = 1'b0;
  logic [31:0] act_q[$];
  int          wr_cyc[$];
  always @(posedge clk) pcyc <= pcyc + 1;
  always @(negedge clk) begin
    if (out_wren) begin
      act_q.push_back(out_data);
      wr_cyc.push_back(pcyc);
    end
    if (out_load) loads++;
    if (out_wren && out_load) overlap = 1'b1;
  end

  // Reference model state.
  logic [31:0] exp_q[$];
  bit          exp_el, exp_ef;
  int          exp_fc, exp_loads;
  int          ab, lb;
  int          lens[8];
  int          gaps[8];
  int          fall_pcyc[8];
  int          drop_at;

  typedef struct {
    int nl; int oi; int ol; int og;
    int wr; bit el; bit ef; int fc;
  } row_t;
  row_t tbl[7];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_vs = 1'b0;
      in_de = 1'b0;
    end
  endtask

  task automatic vsync();
    @(negedge clk);
    in_vs = 1'b1;
    in_de = 1'b0;
    @(negedge clk);
    in_vs = 1'b1;
    idle(3);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_el = 1'b0;
    exp_ef = 1'b0;
    exp_fc = 0;
    exp_loads = 0;
    ab = act_q.size();
    lb = loads;
    drop_at = -1;
  endtask

  task automatic nominal_plan();
    for (int i = 0; i < 8; i++) begin
      lens[i] = H;
      gaps[i] = 4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    enable = 1'b0;
    idle(2);
    clear_model();
    nominal_plan();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drives one frame and, when active, records what the gate must write:
  // only the first V lines count, each gives min(len,H) pixels plus fill up to H
  // (fill limited by the blanking that follows), and the frame completes at V lines.
  task automatic run_frame(input int nl, input bit active);
    int   written;
    bit   proc;
    logic [7:0] r, g, b;
    written = 0;
    vsync();
    if (active) exp_loads++;
    for (int i = 0; i < nl; i++) begin
      proc = active && (written < V);
      if (i == drop_at) enable = 1'b0;
      for (int p = 0; p < lens[i]; p++) begin
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
        in_vs = 1'b0;
        in_de = 1'b1;
        in_r = r;
        in_g = g;
        in_b = b;
        if (proc && p < H) exp_q.push_back({r, g, b, 8'hFF});
      end
      fall_pcyc[i] = pcyc + 1;
      if (proc) begin
        if (lens[i] != H) exp_el = 1'b1;
`ifdef ISP_WR_GATE_PAD_EN
        if (lens[i] < H) repeat (imin(H - lens[i], gaps[i])) exp_q.push_back(32'h0000_00FF);
`endif
        written++;
      end
      idle(gaps[i]);
    end
    if (active) begin
      if (written < V) exp_ef = 1'b1;
      if (written == V) exp_fc++;
    end
  endtask

  task automatic end_seq();
    enable = 1'b0;
    vsync();
    idle(4);
  endtask

  task automatic finish_check(input string n, input int e_wr, input bit e_el, input bit e_ef, input int e_fc);
    int got;
    int ok;
    got = act_q.size() - ab;
    ok = 0;
    chk({n, " writes"}, got, e_wr);
    for (int i = 0; i < got && i < exp_q.size(); i++)
      if (act_q[ab + i] === exp_q[i]) ok++;
    chk({n, " data_match"}, ok, exp_q.size());
    chk({n, " loads"}, loads - lb, exp_loads);
    chk({n, " err_line"}, err_line, e_el);
    chk({n, " err_frame"}, err_frame, e_ef);
    chk({n, " frame_cnt"}, frame_cnt, e_fc);
  endtask

  initial begin
    int nf;
    rstn = 1'b0;
    enable = 1'b0;
    in_vs = 1'b0;
    in_de = 1'b0;
    in_r = '0;
    in_g = '0;
    in_b = '0;
    clear_model();
    nominal_plan();

    tbl[0] = '{4, 0, 8, 4, 32, 1'b0, 1'b0, 1};
    tbl[1] = '{4, 1, 11, 4, 32, 1'b1, 1'b0, 1};
`ifdef ISP_WR_GATE_PAD_EN
    tbl[2] = '{4, 1, 5, 10, 32, 1'b1, 1'b0, 1};
    tbl[5] = '{4, 1, 5, 2, 31, 1'b1, 1'b0, 1};
    tbl[6] = '{4, 3, 3, 4, 32, 1'b1, 1'b0, 1};
`else
    tbl[2] = '{4, 1, 5, 10, 29, 1'b1, 1'b0, 1};
    tbl[5] = '{4, 1, 5, 2, 29, 1'b1, 1'b0, 1};
    tbl[6] = '{4, 3, 3, 4, 27, 1'b1, 1'b0, 1};
`endif
    tbl[3] = '{2, 0, 8, 4, 16, 1'b0, 1'b1, 0};
    tbl[4] = '{6, 0, 8, 4, 32, 1'b0, 1'b0, 1};

    // Reset state.
    idle(2);
    chk("rst out_load", out_load, 1'b0);
    chk("rst out_wren", out_wren, 1'b0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst frame_cnt", frame_cnt, 16'h0);
    chk("rst errs", {err_line, err_frame}, 2'b00);
    @(negedge clk);
    rstn = 1'b1;

    // Nominal: skipped frame, then two written frames.
    do_reset();
    enable = 1'b1;
    run_frame(4, 0);
    chk("skip_no_wr", act_q.size() - ab, 0);
    run_frame(4, 1);
    run_frame(4, 1);
    end_seq();
    finish_check("nominal3", 64, 1'b0, 1'b0, 2);

    // Scenario table.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      enable = 1'b1;
      run_frame(4, 0);
      for (int i = 0; i < 8; i++) gaps[i] = 4;
      lens[tbl[t].oi] = tbl[t].ol;
      gaps[tbl[t].oi] = tbl[t].og;
      gaps[tbl[t].nl - 1] = 12;
      run_frame(tbl[t].nl, 1);
      end_seq();
      finish_check($sformatf("scen%0d", t), tbl[t].wr, tbl[t].el, tbl[t].ef, tbl[t].fc);
    end

    // Short line timing: fill words back-to-back right after the last pixel.
    do_reset();
    enable = 1'b1;
    lens[1] = 5;
    gaps[1] = 10;
    gaps[3] = 12;
    run_frame(4, 0);
    run_frame(4, 1);
    if (act_q.size() - ab >= 17) begin
`ifdef ISP_WR_GATE_PAD_EN
      chk("pad_start", wr_cyc[ab + 13], fall_pcyc[1] + 1);
      chk("pad_after_data", wr_cyc[ab + 13] - wr_cyc[ab + 12], 1);
      chk("pad_b2b", wr_cyc[ab + 15] - wr_cyc[ab + 13], 2);
      chk("pad_word", act_q[ab + 14], 32'h0000_00FF);
      chk("line2_start", wr_cyc[ab + 16], fall_pcyc[1] + 11);
`else
      chk("nopad_line2_start", wr_cyc[ab + 13], fall_pcyc[1] + 11);
`endif
    end else begin
      chk("pad_seq writes", act_q.size() - ab, 17);
    end
    end_seq();
`ifdef ISP_WR_GATE_PAD_EN
    finish_check("pad_seq", 32, 1'b1, 1'b0, 1);
`else
    finish_check("pad_seq", 29, 1'b1, 1'b0, 1);
`endif

    // Enable dropped mid-frame: frame completes, then the gate idles.
    do_reset();
    enable = 1'b1;
    run_frame(4, 0);
    drop_at = 2;
    run_frame(4, 1);
    drop_at = -1;
    run_frame(4, 0);
    idle(4);
    finish_check("en_drop", 32, 1'b0, 1'b0, 1);

    // Asynchronous reset in the middle of a line, then skip restarts.
    do_reset();
    enable = 1'b1;
    lens[1] = 11;
    run_frame(4, 0);
    run_frame(4, 1);
    vsync();
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      in_de = 1'b1;
      in_r = 8'(p);
      in_g = 8'h11;
      in_b = 8'h22;
    end
    chk("pre_rst wren", out_wren, 1'b1);
    chk("pre_rst frame_cnt", frame_cnt, 16'd1);
    chk("pre_rst err_line", err_line, 1'b1);
    rstn = 1'b0;
    #1;
    chk("async_rst wren", out_wren, 1'b0);
    chk("async_rst data", out_data, 32'h0);
    chk("async_rst frame_cnt", frame_cnt, 16'h0);
    chk("async_rst errs", {err_line, err_frame, out_load}, 3'b000);
    idle(2);
    clear_model();
    nominal_plan();
    @(negedge clk);
    rstn = 1'b1;
    run_frame(4, 0);
    run_frame(4, 1);
    end_seq();
    finish_check("rst_resume", 32, 1'b0, 1'b0, 1);

    // Random frames against the model.
    do_reset();
    enable = 1'b1;
    run_frame(4, 0);
    nf = 6;
    for (int f = 0; f < nf; f++) begin
      int nl;
      nl = $urandom_range(2, 6);
      for (int i = 0; i < nl; i++) begin
        lens[i] = $urandom_range(3, 11);
        gaps[i] = $urandom_range(1, 10);
      end
      gaps[nl - 1] = 12;
      run_frame(nl, 1);
    end
    end_seq();
    finish_check("random", exp_q.size(), exp_el, exp_ef, exp_fc);

    chk("no_wren_load_overlap", overlap, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
